hp35_key_scanner: RTL and testbench



---
 rtl/hp35_key_scanner.sv | 233 +++++++++++++++++++++++
 tb/tb_hp35_key_scanner.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hp35_key_scanner.sv
// rtl/hp35_key_scanner.sv - HP-35 keyboard matrix scanner with whole-frame debounce and single-key lockout
module hp35_key_scanner #(
    parameter int ROWS      = 8,
    parameter int COLS      = 5,
    parameter int SCAN_DIV  = 256,
    parameter int DEB_SCANS = 4
) (
    input  logic            osc_in,
    input  logic            rst_n,
    input  logic            scan_en,
    input  logic [COLS-1:0] col_i,
    output logic [ROWS-1:0] row_o,
    output logic [4:0]      col_o,
    output logic [5:0]      key_code,
    output logic            key_dn,
    output logic            key_evt,
    output logic            multi
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [2:0]    ROW_LAST = 3'(ROWS - 1);
    localparam logic [3:0]    DEB_N    = 4'(DEB_SCANS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_CHK,
        S_DOWN,
        S_RELEASE_CHK
    } state_t;

    logic [COLS-1:0] col_meta_q, col_meta_d;
    logic [COLS-1:0] col_s_q, col_s_d;
    logic [DW-1:0]   div_q, div_d;
    logic [2:0]      row_q, row_d;
    logic [1:0]      fcnt_q, fcnt_d;
    logic            fvalid_q, fvalid_d;
    logic [5:0]      fkey_q, fkey_d;
    logic            fheld_q, fheld_d;
    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [5:0]      cand_q, cand_d;
    logic [ROWS-1:0] row_o_q, row_o_d;
    logic [4:0]      col_o_q, col_o_d;
    logic [5:0]      key_code_q, key_code_d;
    logic            key_dn_q, key_dn_d;
    logic            key_evt_q, key_evt_d;
    logic            multi_q, multi_d;

    logic [7:0] col_ext;
    logic [2:0] row_first;
    logic [1:0] row_cnt;
    logic       row_hit;
    logic       row_held;
    logic [2:0] cnt_sum;
    logic [1:0] tot_cnt;
    logic [5:0] tot_key;
    logic       tot_held;
    logic       sample;
    logic       frame_end;
    logic       one_key;

    // Per-row view of the synchronised columns, merged with the frame so far
    always_comb begin
        col_ext = '0;
        col_ext[COLS-1:0] = col_s_q;
        row_first = '0;
        row_cnt = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (col_ext[i]) row_first = 3'(i);
        end
        for (int i = 0; i < COLS; i++) begin
            if (col_ext[i] && row_cnt != 2'd2) row_cnt = row_cnt + 2'd1;
        end
        row_hit  = |col_ext;
        row_held = (row_q == key_code_q[5:3]) && col_ext[key_code_q[2:0]];
        cnt_sum  = {1'b0, fcnt_q} + {1'b0, row_cnt};
        tot_cnt  = (cnt_sum >= 3'd2) ? 2'd2 : cnt_sum[1:0];
        tot_key  = fvalid_q ? fkey_q : (row_hit ? {row_q, row_first} : 6'd0);
        tot_held = fheld_q | row_held;
        sample    = scan_en && (div_q == DIV_LAST);
        frame_end = sample && (row_q == ROW_LAST);
        one_key   = (tot_cnt == 2'd1);
    end

    always_comb begin
        col_meta_d = col_i;
        col_s_d    = col_meta_q;
        div_d      = div_q + DW'(1);
        row_d      = row_q;
        fcnt_d     = fcnt_q;
        fvalid_d   = fvalid_q;
        fkey_d     = fkey_q;
        fheld_d    = fheld_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        key_code_d = key_code_q;
        key_evt_d  = 1'b0;
        multi_d    = multi_q;

        if (div_q == DIV_LAST) begin
            div_d = '0;
            row_d = (row_q == ROW_LAST) ? 3'd0 : row_q + 3'd1;
        end

        if (sample) begin
            fcnt_d   = tot_cnt;
            fvalid_d = fvalid_q | row_hit;
            fkey_d   = tot_key;
            fheld_d  = tot_held;
        end

        if (frame_end) begin
            fcnt_d   = '0;
            fvalid_d = 1'b0;
            fkey_d   = '0;
            fheld_d  = 1'b0;
            multi_d  = (tot_cnt == 2'd2);
            unique case (state_q)
                S_IDLE: begin
                    if (one_key) begin
                        cand_d = tot_key;
                        cnt_d  = 4'd1;
                        if (DEB_N == 4'd1) begin
                            state_d    = S_DOWN;
                            key_evt_d  = 1'b1;
                            key_code_d = tot_key;
                        end else begin
                            state_d = S_PRESS_CHK;
                        end
                    end
                end
                S_PRESS_CHK: begin
                    if (one_key && tot_key == cand_q) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 >= DEB_N) begin
                            state_d    = S_DOWN;
                            key_evt_d  = 1'b1;
                            key_code_d = cand_q;
                        end
                    end else if (one_key) begin
                        cand_d = tot_key;
                        cnt_d  = 4'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DOWN: begin
                    if (!tot_held) begin
                        cnt_d   = 4'd1;
                        state_d = (DEB_N == 4'd1) ? S_IDLE : S_RELEASE_CHK;
                    end
                end
                S_RELEASE_CHK: begin
                    if (tot_held) begin
                        state_d = S_DOWN;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 >= DEB_N) state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Disabling scanning parks everything at the start of a fresh frame
        if (!scan_en) begin
            div_d     = '0;
            row_d     = '0;
            fcnt_d    = '0;
            fvalid_d  = 1'b0;
            fkey_d    = '0;
            fheld_d   = 1'b0;
            state_d   = S_IDLE;
            cnt_d     = '0;
            key_evt_d = 1'b0;
            multi_d   = 1'b0;
        end

        key_dn_d = (state_d == S_DOWN) || (state_d == S_RELEASE_CHK);
        col_o_d  = key_dn_d ? (5'b00001 << key_code_d[2:0]) : 5'b00000;
        row_o_d  = scan_en ? ~(ROWS'(1) << row_d) : '1;
    end

    always_ff @(posedge osc_in or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q <= '0;
            col_s_q    <= '0;
            div_q      <= '0;
            row_q      <= '0;
            fcnt_q     <= '0;
            fvalid_q   <= 1'b0;
            fkey_q     <= '0;
            fheld_q    <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cand_q     <= '0;
            row_o_q    <= '1;
            col_o_q    <= '0;
            key_code_q <= '0;
            key_dn_q   <= 1'b0;
            key_evt_q  <= 1'b0;
            multi_q    <= 1'b0;
        end else begin
            col_meta_q <= col_meta_d;
            col_s_q    <= col_s_d;
            div_q      <= div_d;
            row_q      <= row_d;
            fcnt_q     <= fcnt_d;
            fvalid_q   <= fvalid_d;
            fkey_q     <= fkey_d;
            fheld_q    <= fheld_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            row_o_q    <= row_o_d;
            col_o_q    <= col_o_d;
            key_code_q <= key_code_d;
            key_dn_q   <= key_dn_d;
            key_evt_q  <= key_evt_d;
            multi_q    <= multi_d;
        end
    end

    assign row_o    = row_o_q;
    assign col_o    = col_o_q;
    assign key_code = key_code_q;
    assign key_dn   = key_dn_q;
    assign key_evt  = key_evt_q;
    assign multi    = multi_q;

endmodule

// File: tb/tb_hp35_key_scanner.sv
// tb/tb_hp35_key_scanner.sv - frame-level table and randomized checks for hp35_key_scanner
module tb_hp35_key_scanner;

    localparam int ROWS = 8;
    localparam int COLS = 5;
    localparam int SDIV = 4;
    localparam int DEB  = 2;

    localparam logic [39:0] K32 = 40'd1 << 17;
    localparam logic [39:0] K50 = 40'd1 << 25;
    localparam logic [39:0] K11 = 40'd1 << 6;
    localparam logic [39:0] K64 = 40'd1 << 34;
    localparam logic [39:0] K20 = 40'd1 << 10;
    localparam logic [39:0] K21 = 40'd1 << 11;

    typedef struct {
        logic [39:0] keys;
        logic        dn;
        logic [5:0]  code;
        logic [4:0]  col;
        logic        evt;
        logic        mul;
    } vec_t;

    logic            osc_in = 1'b0;
    logic            rst_n = 1'b0;
    logic            scan_en = 1'b1;
    logic [COLS-1:0] col_i;
    logic [ROWS-1:0] row_o;
    logic [4:0]      col_o;
    logic [5:0]      key_code;
    logic            key_dn;
    logic            key_evt;
    logic            multi;

    logic [39:0] keys = '0;
    int n = 0;
    int tests = 0;
    int fails = 0;

    int         held, streak, streak_key, rel;
    logic [5:0] m_code;
    logic       m_dn, m_evt, m_multi;
    logic [4:0] m_col;

    hp35_key_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .DEB_SCANS(DEB)
    ) dut (
        .osc_in(osc_in), .rst_n(rst_n), .scan_en(scan_en), .col_i(col_i),
        .row_o(row_o), .col_o(col_o), .key_code(key_code),
        .key_dn(key_dn), .key_evt(key_evt), .multi(multi)
    );

    always #5 osc_in = ~osc_in;

    // Physical matrix: a pressed key connects its row strobe to its column
    always_comb begin
        col_i = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!row_o[r] && keys[r*COLS+c]) col_i[c] = 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        logic [7:0] er;
        @(posedge osc_in);
        #1;
        n++;
        er = (scan_en && rst_n) ? ~(8'h01 << ((n / SDIV) % ROWS)) : 8'hFF;
        check($sformatf("row_o@%0d", n), row_o, er);
    endtask

    task automatic run_frame(input logic [39:0] ks);
        int ev;
        keys = ks;
        ev = 0;
        for (int i = 0; i < ROWS * SDIV; i++) begin
            step();
            if (i < ROWS * SDIV - 1) ev += int'(key_evt);
        end
        check("stray_evt", ev, 0);
    endtask

    task automatic cmp(input string tag, input logic dn, input logic [5:0] code,
                       input logic [4:0] col, input logic evt, input logic mul);
        check({tag, "/key_dn"}, key_dn, dn);
        check({tag, "/key_code"}, key_code, code);
        check({tag, "/col_o"}, col_o, col);
        check({tag, "/key_evt"}, key_evt, evt);
        check({tag, "/multi"}, multi, mul);
    endtask

    task automatic model_reset();
        held = -1; streak = 0; streak_key = -1; rel = 0; m_code = '0;
    endtask

    // Debounce expressed as streak counters over whole frames
    task automatic model_frame(input logic [39:0] ks);
        int nk, first;
        nk = $countones(ks);
        first = -1;
        for (int k = 39; k >= 0; k--) if (ks[k]) first = k;
        m_evt = 1'b0;
        m_multi = (nk >= 2);
        if (held < 0) begin
            if (nk == 1) begin
                if (streak > 0 && first == streak_key) streak++;
                else begin streak_key = first; streak = 1; end
                if (streak >= DEB) begin
                    held = first; m_evt = 1'b1; rel = 0;
                    m_code = 6'((first / COLS) * 8 + first % COLS);
                end
            end else begin
                streak = 0;
            end
        end else begin
            if (ks[held]) rel = 0;
            else rel++;
            if (rel >= DEB) begin held = -1; streak = 0; end
        end
        m_dn  = (held >= 0);
        m_col = (held >= 0) ? (5'b00001 << (held % COLS)) : 5'b00000;
    endtask

    initial begin
        vec_t tbl[$];
        int pool[4] = '{0, 12, 24, 39};
        logic [39:0] ks, prev;
        int sel;

        tbl.push_back('{40'd0,     1'b0, 6'h00, 5'h00, 1'b0, 1'b0});
        tbl.push_back('{K32,       1'b0, 6'h00, 5'h00, 1'b0, 1'b0});
        tbl.push_back('{K32,       1'b1, 6'h1A, 5'h04, 1'b1, 1'b0});
        tbl.push_back('{K32,       1'b1, 6'h1A, 5'h04, 1'b0, 1'b0});
        tbl.push_back('{40'd0,     1'b1, 6'h1A, 5'h04, 1'b0, 1'b0});
        tbl.push_back('{40'd0,     1'b0, 6'h1A, 5'h00, 1'b0, 1'b0});
        tbl.push_back('{K50,       1'b0, 6'h1A, 5'h00, 1'b0, 1'b0});
        tbl.push_back('{40'd0,     1'b0, 6'h1A, 5'h00, 1'b0, 1'b0});
        tbl.push_back('{K50,       1'b0, 6'h1A, 5'h00, 1'b0, 1'b0});
        tbl.push_back('{K50,       1'b1, 6'h28, 5'h01, 1'b1, 1'b0});
        tbl.push_back('{40'd0,     1'b1, 6'h28, 5'h01, 1'b0, 1'b0});
        tbl.push_back('{40'd0,     1'b0, 6'h28, 5'h00, 1'b0, 1'b0});
        tbl.push_back('{K11,       1'b0, 6'h28, 5'h00, 1'b0, 1'b0});
        tbl.push_back('{K11,       1'b1, 6'h09, 5'h02, 1'b1, 1'b0});
        tbl.push_back('{K11 | K64, 1'b1, 6'h09, 5'h02, 1'b0, 1'b1});
        tbl.push_back('{K11 | K64, 1'b1, 6'h09, 5'h02, 1'b0, 1'b1});
        tbl.push_back('{K64,       1'b1, 6'h09, 5'h02, 1'b0, 1'b0});
        tbl.push_back('{K64,       1'b0, 6'h09, 5'h00, 1'b0, 1'b0});
        tbl.push_back('{K64,       1'b0, 6'h09, 5'h00, 1'b0, 1'b0});
        tbl.push_back('{K64,       1'b1, 6'h34, 5'h10, 1'b1, 1'b0});
        tbl.push_back('{40'd0,     1'b1, 6'h34, 5'h10, 1'b0, 1'b0});
        tbl.push_back('{K64,       1'b1, 6'h34, 5'h10, 1'b0, 1'b0});
        tbl.push_back('{K64,       1'b1, 6'h34, 5'h10, 1'b0, 1'b0});
        tbl.push_back('{40'd0,     1'b1, 6'h34, 5'h10, 1'b0, 1'b0});
        tbl.push_back('{40'd0,     1'b0, 6'h34, 5'h00, 1'b0, 1'b0});
        tbl.push_back('{K20,       1'b0, 6'h34, 5'h00, 1'b0, 1'b0});
        tbl.push_back('{K20 | K21, 1'b0, 6'h34, 5'h00, 1'b0, 1'b1});
        tbl.push_back('{K20,       1'b0, 6'h34, 5'h00, 1'b0, 1'b0});
        tbl.push_back('{K21,       1'b0, 6'h34, 5'h00, 1'b0, 1'b0});
        tbl.push_back('{K21,       1'b1, 6'h11, 5'h02, 1'b1, 1'b0});
        tbl.push_back('{40'd0,     1'b1, 6'h11, 5'h02, 1'b0, 1'b0});
        tbl.push_back('{40'd0,     1'b0, 6'h11, 5'h00, 1'b0, 1'b0});

        repeat (3) @(negedge osc_in);
        check("rst/row_o", row_o, 8'hFF);
        cmp("rst", 1'b0, 6'h00, 5'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        n = 0;

        foreach (tbl[i]) begin
            run_frame(tbl[i].keys);
            cmp($sformatf("tbl%0d", i), tbl[i].dn, tbl[i].code, tbl[i].col, tbl[i].evt, tbl[i].mul);
        end

        run_frame(K32);
        cmp("en_pre1", 1'b0, 6'h11, 5'h00, 1'b0, 1'b0);
        run_frame(K32);
        cmp("en_pre2", 1'b1, 6'h1A, 5'h04, 1'b1, 1'b0);
        repeat (10) step();
        scan_en = 1'b0;
        step();
        cmp("en_off", 1'b0, 6'h1A, 5'h00, 1'b0, 1'b0);
        repeat (5) step();
        scan_en = 1'b1;
        n = 0;
        run_frame(K32);
        cmp("en_on1", 1'b0, 6'h1A, 5'h00, 1'b0, 1'b0);
        run_frame(K32);
        cmp("en_on2", 1'b1, 6'h1A, 5'h04, 1'b1, 1'b0);
        repeat (7) step();

        #3;
        rst_n = 1'b0;
        #1;
        check("arst/row_o", row_o, 8'hFF);
        cmp("arst", 1'b0, 6'h00, 5'h00, 1'b0, 1'b0);
        keys = '0;
        @(negedge osc_in);
        @(negedge osc_in);
        rst_n = 1'b1;
        n = 0;

        model_reset();
        prev = '0;
        for (int f = 0; f < 150; f++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 5) ks = prev;
            else if (sel < 7) ks = '0;
            else if (sel < 9) ks = 40'd1 << pool[$urandom_range(0, 3)];
            else ks = (40'd1 << pool[$urandom_range(0, 3)]) | (40'd1 << pool[$urandom_range(0, 3)]);
            run_frame(ks);
            model_frame(ks);
            cmp($sformatf("rnd%0d", f), m_dn, m_code, m_col, m_evt, m_multi);
            prev = ks;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
